ft_wb_master: RTL

FT_WB_MASTER -- requirements
Module: ft_wb_master

---
 rtl/ft_wb_master.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/ft_wb_master.sv
// Host-command to Wishbone classic master: PING, multi-word WRITE and READ, with an ack timeout and host abort.
// One bus word per command beat; responses are held until the host interface signals oh_ready.
module ft_wb_master #(
  parameter int TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        master_ready,
  input  logic        ih_ready,
  input  logic        ih_reset,
  input  logic [31:0] in_command,
  input  logic [31:0] in_address,
  input  logic [31:0] in_data,
  input  logic [27:0] in_data_count,
  input  logic        oh_ready,
  output logic        oh_en,
  output logic [31:0] out_status,
  output logic [31:0] out_address,
  output logic [31:0] out_data,
  output logic [27:0] out_data_count,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WB_WRITE  = 3'd1;
  localparam logic [2:0] WAIT_DATA = 3'd2;
  localparam logic [2:0] WB_READ   = 3'd3;
  localparam logic [2:0] SEND_RESP = 3'd4;
  localparam logic [2:0] SEND_READ = 3'd5;

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

  logic [2:0]  state;
  logic [31:0] start_addr;
  logic [23:0] remaining;
  logic [3:0]  opcode;
  logic [31:0] tcount;

  logic        ack;
  logic        timeout_hit;
  logic [23:0] eff_count;
  logic [23:0] rem_next;
  logic [3:0]  in_op;
  logic        unused_bits;

  assign in_op        = in_command[3:0];
  assign ack          = wbm_ack_i & wbm_stb_o;
  assign timeout_hit  = wbm_stb_o & ~wbm_ack_i & (tcount == TIMEOUT_LAST);
  assign eff_count    = (in_data_count[23:0] == 24'd0) ? 24'd1 : in_data_count[23:0];
  assign rem_next     = (remaining == 24'd0) ? 24'd0 : remaining - 24'd1;
  assign unused_bits  = ^{in_command[31:4], in_data_count[27:24]};

  assign master_ready = (state == IDLE) || (state == WAIT_DATA);
  // Strobe is gated by oh_ready directly so it can never fire into a stalled host.
  assign oh_en        = oh_ready && ((state == SEND_RESP) || (state == SEND_READ));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      start_addr     <= '0;
      remaining      <= '0;
      opcode         <= '0;
      tcount         <= '0;
      out_status     <= '0;
      out_address    <= '0;
      out_data       <= '0;
      out_data_count <= '0;
      wbm_cyc_o      <= 1'b0;
      wbm_stb_o      <= 1'b0;
      wbm_we_o       <= 1'b0;
      wbm_adr_o      <= '0;
      wbm_dat_o      <= '0;
      wbm_sel_o      <= '0;
    end else if (ih_reset) begin
      wbm_cyc_o      <= 1'b0;
      wbm_stb_o      <= 1'b0;
      wbm_we_o       <= 1'b0;
      wbm_sel_o      <= '0;
      remaining      <= '0;
      tcount         <= '0;
      out_status     <= 32'h0C;
      out_address    <= '0;
      out_data       <= '0;
      out_data_count <= '0;
      state          <= SEND_RESP;
    end else begin
      case (state)
        IDLE: begin
          if (ih_ready) begin
            opcode <= in_op;
            case (in_op)
              4'd0: begin
                out_status     <= 32'h0F;
                out_address    <= '0;
                out_data       <= '0;
                out_data_count <= '0;
                state          <= SEND_RESP;
              end
              4'd1, 4'd2: begin
                start_addr <= in_address;
                wbm_adr_o  <= in_address;
                remaining  <= eff_count;
                wbm_dat_o  <= in_data;
                wbm_cyc_o  <= 1'b1;
                wbm_stb_o  <= 1'b1;
                wbm_we_o   <= (in_op == 4'd1);
                wbm_sel_o  <= 4'hF;
                tcount     <= '0;
                state      <= (in_op == 4'd1) ? WB_WRITE : WB_READ;
              end
              default: begin
                out_status     <= {27'd0, 1'b1, ~in_op};
                out_address    <= '0;
                out_data       <= '0;
                out_data_count <= '0;
                state          <= SEND_RESP;
              end
            endcase
          end
        end
        WB_WRITE, WB_READ: begin
          if (ack) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            if (state == WB_WRITE) begin
              wbm_adr_o <= wbm_adr_o + 32'd1;
              remaining <= rem_next;
              if (rem_next != 24'd0) begin
                state <= WAIT_DATA;
              end else begin
                out_status     <= 32'h0E;
                out_address    <= start_addr;
                out_data       <= wbm_dat_o;
                out_data_count <= '0;
                state          <= SEND_RESP;
              end
            end else begin
              out_status     <= 32'h0D;
              out_address    <= start_addr;
              out_data       <= wbm_dat_i;
              out_data_count <= {4'd0, rem_next};
              state          <= SEND_READ;
            end
          end else if (timeout_hit) begin
            // Abandon the whole transfer; the host only sees the timeout status.
            wbm_cyc_o      <= 1'b0;
            wbm_stb_o      <= 1'b0;
            wbm_we_o       <= 1'b0;
            remaining      <= '0;
            tcount         <= '0;
            out_status     <= {27'd0, 1'b1, ~opcode};
            out_address    <= start_addr;
            out_data       <= '0;
            out_data_count <= '0;
            state          <= SEND_RESP;
          end else begin
            tcount <= tcount + 32'd1;
          end
        end
        WAIT_DATA: begin
          if (ih_ready) begin
            wbm_dat_o <= in_data;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= 1'b1;
            tcount    <= '0;
            state     <= WB_WRITE;
          end
        end
        SEND_READ: begin
          if (oh_ready) begin
            remaining <= rem_next;
            if (rem_next != 24'd0) begin
              wbm_adr_o <= wbm_adr_o + 32'd1;
              wbm_cyc_o <= 1'b1;
              wbm_stb_o <= 1'b1;
              tcount    <= '0;
              state     <= WB_READ;
            end else begin
              state <= IDLE;
            end
          end
        end
        SEND_RESP: begin
          if (oh_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
